// File: rtl/sdram_access_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_access_arbiter
//
// Shares the single SDRAM controller command port between three requesters:
// refresh (queued as a debt counter fed by DO_REFRESH rising edges), video
// line fetch and CPU. One command is issued per grant, and the arbiter waits
// for the core's completion pulse before it grants again. CPU_WAITn stalls the
// CPU until its access has completed.
//
// Optional feature: define CPU_STARVE_GUARD_EN to build a starvation counter
// that lets the CPU outrank video after STARVE_MAX consecutive losses.
// Without it the priority is strictly refresh > video > CPU.
//
// Ports
//   CLK, RSTn            SDRAM clock (rising edge), async active-low reset
//   DO_REFRESH           refresh tick, async; each rising edge adds one refresh
//   VIDEO_RDn, Video_A   video read request (level, active low) and address
//   CPU_RDn, CPU_WRn     CPU read/write requests (level, active low)
//   CPU_A                CPU address
//   MEM_DONE             one-cycle completion pulse from the core
//   MEM_START            one-cycle start pulse to the core
//   MEM_CMD              00 idle, 01 read, 10 write, 11 auto-refresh
//   MEM_A                address of the issued command
//   MEM_SRC              00 none, 01 cpu, 10 video, 11 refresh
//   CPU_WAITn            low while a CPU request is pending or in service
//   ARB_ERR              sticky timeout-abort flag
//   dbg_state            FSM state: 0 IDLE, 1 ISSUE, 2 BUSY
//
// Core handshake: MEM_START is high for exactly one cycle (ISSUE) with
// MEM_CMD/MEM_A/MEM_SRC valid; those stay stable until MEM_DONE (a one-cycle
// pulse) is seen in BUSY. MEM_DONE in any other state is ignored. If MEM_DONE
// does not arrive within TIMEOUT BUSY cycles the command is aborted.
// ---------------------------------------------------------------------------
module sdram_access_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int REF_DEBT_MAX = 4,
  parameter int STARVE_MAX   = 3,
  parameter int TIMEOUT      = 255
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              DO_REFRESH,
  input  logic              VIDEO_RDn,
  input  logic [ADDR_W-1:0] Video_A,
  input  logic              CPU_RDn,
  input  logic              CPU_WRn,
  input  logic [ADDR_W-1:0] CPU_A,
  input  logic              MEM_DONE,
  output logic              MEM_START,
  output logic [1:0]        MEM_CMD,
  output logic [ADDR_W-1:0] MEM_A,
  output logic [1:0]        MEM_SRC,
  output logic              CPU_WAITn,
  output logic              ARB_ERR,
  output logic [1:0]        dbg_state
);

  localparam int DEBT_W = $clog2(REF_DEBT_MAX + 1);

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_CPU  = 2'b01;
  localparam logic [1:0] SRC_VID  = 2'b10;
  localparam logic [1:0] SRC_REF  = 2'b11;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_RD   = 2'b01;
  localparam logic [1:0] CMD_WR   = 2'b10;
  localparam logic [1:0] CMD_REF  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              ref_s1;
  logic              ref_s2;
  logic              ref_s3;
  logic              ref_rise;
  logic [DEBT_W-1:0] debt;
  logic [7:0]        tmo;
  logic              tmo_hit;
  logic              busy_done;
  logic              ref_dec;
  logic              cpu_lock;
  logic              cpu_req;
  logic              vid_req;
  logic              ref_req;
  logic              cpu_first;
  logic [1:0]        win_src;

  // Two-flop synchroniser plus one delay flop for the edge detector.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ref_s1 <= 1'b0;
      ref_s2 <= 1'b0;
      ref_s3 <= 1'b0;
    end else begin
      ref_s1 <= DO_REFRESH;
      ref_s2 <= ref_s1;
      ref_s3 <= ref_s2;
    end
  end

  assign ref_rise = ref_s2 & ~ref_s3;

  // A CPU request that has just been completed stays locked out until the
  // CPU has released both strobes, so a held request is not served twice.
  assign cpu_req = (~CPU_RDn | ~CPU_WRn) & ~cpu_lock;
  assign vid_req = ~VIDEO_RDn;
  assign ref_req = (debt != '0);

  assign tmo_hit   = (tmo == 8'(TIMEOUT - 1));
  assign busy_done = (state == S_BUSY) && (MEM_DONE || tmo_hit);
  assign ref_dec   = busy_done && (MEM_SRC == SRC_REF);

`ifdef CPU_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  logic [STARVE_W-1:0] starve;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      starve <= '0;
    end else if (state == S_IDLE) begin
      if (win_src == SRC_CPU) begin
        starve <= '0;
      end else if (win_src == SRC_VID && cpu_req && starve != STARVE_W'(STARVE_MAX)) begin
        starve <= starve + 1'b1;
      end
    end
  end

  assign cpu_first = (starve >= STARVE_W'(STARVE_MAX));
`else
  // STARVE_MAX only matters with the guard built; this is constant false.
  assign cpu_first = (STARVE_MAX < 0);
`endif

  // Winner selection: refresh always first, then video unless the CPU has
  // been starved long enough to outrank it.
  always_comb begin
    win_src = SRC_NONE;
    if (ref_req) begin
      win_src = SRC_REF;
    end else if (cpu_req && (cpu_first || !vid_req)) begin
      win_src = SRC_CPU;
    end else if (vid_req) begin
      win_src = SRC_VID;
    end
  end

  // FSM: state register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win_src != SRC_NONE) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_BUSY;
      S_BUSY:  if (busy_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    MEM_START = (state == S_ISSUE);
    CPU_WAITn = ~(cpu_req | (MEM_SRC == SRC_CPU));
    dbg_state = state;
  end

  // Command latch: captured at grant, cmd/src cleared on completion while
  // the address is left as it was.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      MEM_CMD <= CMD_IDLE;
      MEM_A   <= '0;
      MEM_SRC <= SRC_NONE;
    end else if (state == S_IDLE && win_src != SRC_NONE) begin
      MEM_SRC <= win_src;
      case (win_src)
        SRC_REF: begin
          MEM_CMD <= CMD_REF;
          MEM_A   <= '0;
        end
        SRC_VID: begin
          MEM_CMD <= CMD_RD;
          MEM_A   <= Video_A;
        end
        default: begin
          // Write wins when both CPU strobes are low.
          MEM_CMD <= CPU_WRn ? CMD_RD : CMD_WR;
          MEM_A   <= CPU_A;
        end
      endcase
    end else if (busy_done) begin
      MEM_CMD <= CMD_IDLE;
      MEM_SRC <= SRC_NONE;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tmo      <= '0;
      ARB_ERR  <= 1'b0;
      cpu_lock <= 1'b0;
      debt     <= '0;
    end else begin
      if (state == S_BUSY && !busy_done) tmo <= tmo + 1'b1;
      else                               tmo <= '0;

      if (state == S_BUSY && tmo_hit && !MEM_DONE) ARB_ERR <= 1'b1;

      if (busy_done && MEM_SRC == SRC_CPU) cpu_lock <= 1'b1;
      else if (CPU_RDn && CPU_WRn)         cpu_lock <= 1'b0;

      // A new tick and a finished refresh in the same cycle cancel out.
      if (ref_rise && !ref_dec) begin
        if (debt != DEBT_W'(REF_DEBT_MAX)) debt <= debt + 1'b1;
      end else if (!ref_rise && ref_dec) begin
        debt <= debt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_access_arbiter.sv
`timescale 1ns/1ps
module tb_sdram_access_arbiter;

  localparam int ADDR_W = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              do_refresh;
  logic              video_rd_n;
  logic [ADDR_W-1:0] video_a;
  logic              cpu_rd_n;
  logic              cpu_wr_n;
  logic [ADDR_W-1:0] cpu_a;
  logic              mem_done;
  logic              mem_start;
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_a;
  logic [1:0]        mem_src;
  logic              cpu_wait_n;
  logic              arb_err;
  logic [1:0]        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  sdram_access_arbiter #(
    .ADDR_W       (ADDR_W),
    .REF_DEBT_MAX (4),
    .STARVE_MAX   (3),
    .TIMEOUT      (255)
  ) dut (
    .CLK        (clk),
    .RSTn       (rst_n),
    .DO_REFRESH (do_refresh),
    .VIDEO_RDn  (video_rd_n),
    .Video_A    (video_a),
    .CPU_RDn    (cpu_rd_n),
    .CPU_WRn    (cpu_wr_n),
    .CPU_A      (cpu_a),
    .MEM_DONE   (mem_done),
    .MEM_START  (mem_start),
    .MEM_CMD    (mem_cmd),
    .MEM_A      (mem_a),
    .MEM_SRC    (mem_src),
    .CPU_WAITn  (cpu_wait_n),
    .ARB_ERR    (arb_err),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    do_refresh = 1'b0; video_rd_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
    mem_done = 1'b0; video_a = '0; cpu_a = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  // Waits (bounded) for a MEM_START pulse; seen=0 if the budget expires.
  task automatic wait_start(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (mem_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int starts;
    rst_n = 1'b0;
    do_refresh = 1'b0; video_rd_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
    mem_done = 1'b0; video_a = '0; cpu_a = '0;
    #1;
    n_tests++;
    if ({mem_start, mem_cmd, mem_src, cpu_wait_n, arb_err} !== 7'b0_00_00_1_0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, want 0000010",
               {mem_start, mem_cmd, mem_src, cpu_wait_n, arb_err});
    end
    n_tests++;
    if (mem_a !== 20'h0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_addr_state: got a=%0h st=%0d, want a=0 st=0", mem_a, dbg_state);
    end
    repeat (3) step();
    rst_n = 1'b1;
    starts = 0;
    repeat (100) begin
      step();
      if (mem_start === 1'b1) starts++;
    end
    n_tests++;
    if (starts !== 0) begin
      n_fail++;
      $display("FAIL reset_idle: got %0d starts, want 0", starts);
    end
  endtask

  task automatic test_cpu_write();
    bit seen;
    int starts;
    bit wait_bad;
    cpu_a = 20'h12345;
    cpu_wr_n = 1'b0;
    #1;
    n_tests++;
    if (cpu_wait_n !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_wait_drop: got %b, want 0", cpu_wait_n);
    end
    wait_start(10, seen);
    n_tests++;
    if (!seen || mem_cmd !== 2'b10 || mem_a !== 20'h12345 || mem_src !== 2'b01) begin
      n_fail++;
      $display("FAIL cpu_wr_issue: got seen=%0d cmd=%b a=%0h src=%b, want 1 10 12345 01",
               seen, mem_cmd, mem_a, mem_src);
    end
    wait_bad = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (cpu_wait_n !== 1'b0 || mem_start !== 1'b0 || mem_cmd !== 2'b10) wait_bad = 1'b1;
    end
    step();
    if (cpu_wait_n !== 1'b0) wait_bad = 1'b1;
    n_tests++;
    if (wait_bad) begin
      n_fail++;
      $display("FAIL cpu_wr_busy: got wait/start/cmd change before done, want wait=0 held");
    end
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    n_tests++;
    if (cpu_wait_n !== 1'b1 || mem_cmd !== 2'b00 || mem_src !== 2'b00 ||
        mem_a !== 20'h12345 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL cpu_wr_done: got wait=%b cmd=%b src=%b a=%0h st=%0d, want 1 00 00 12345 0",
               cpu_wait_n, mem_cmd, mem_src, mem_a, dbg_state);
    end
    // Request still held low, plus a stray MEM_DONE in IDLE: nothing happens.
    starts = 0;
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    repeat (5) begin
      step();
      if (mem_start === 1'b1) starts++;
    end
    n_tests++;
    if (starts !== 0 || cpu_wait_n !== 1'b1 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL cpu_no_reserve: got starts=%0d wait=%b st=%0d, want 0 1 0",
               starts, cpu_wait_n, dbg_state);
    end
    cpu_wr_n = 1'b1;
    step();
  endtask

  task automatic test_priority();
    bit seen;
    logic [1:0]        exp_src [3];
    logic [1:0]        exp_cmd [3];
    logic [ADDR_W-1:0] exp_a   [3];
    exp_src = '{2'b11, 2'b10, 2'b01};
    exp_cmd = '{2'b11, 2'b01, 2'b01};
    exp_a   = '{20'h0, 20'hA0100, 20'h00ABC};
    // Occupy the port with a video read, then queue all three requesters.
    video_a = 20'hA0000;
    video_rd_n = 1'b0;
    wait_start(10, seen);
    n_tests++;
    if (!seen || mem_src !== 2'b10) begin
      n_fail++;
      $display("FAIL prio_first_video: got seen=%0d src=%b, want 1 10", seen, mem_src);
    end
    video_rd_n = 1'b1;
    do_refresh = 1'b1;
    repeat (6) step();
    do_refresh = 1'b0;
    video_a = 20'hA0100;
    video_rd_n = 1'b0;
    cpu_a = 20'h00ABC;
    cpu_rd_n = 1'b0;
    repeat (2) step();
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    for (int g = 0; g < 3; g++) begin
      wait_start(12, seen);
      n_tests++;
      if (!seen || mem_src !== exp_src[g] || mem_cmd !== exp_cmd[g]) begin
        n_fail++;
        $display("FAIL prio_grant%0d: got seen=%0d src=%b cmd=%b, want 1 %b %b",
                 g, seen, mem_src, mem_cmd, exp_src[g], exp_cmd[g]);
      end
      if (g > 0) begin
        n_tests++;
        if (mem_a !== exp_a[g]) begin
          n_fail++;
          $display("FAIL prio_addr%0d: got %0h, want %0h", g, mem_a, exp_a[g]);
        end
      end
      if (exp_src[g] == 2'b10) video_rd_n = 1'b1;
      step();
      mem_done = 1'b1;
      step();
      mem_done = 1'b0;
    end
    n_tests++;
    if (cpu_wait_n !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_cpu_release: got %b, want 1", cpu_wait_n);
    end
    cpu_rd_n = 1'b1;
    step();
  endtask

  task automatic test_refresh_sat();
    bit seen;
    int starts;
    starts = 0;
    for (int r = 0; r < 6; r++) begin
      do_refresh = 1'b1;
      repeat (2) begin
        step();
        if (mem_start === 1'b1) starts++;
      end
      do_refresh = 1'b0;
      repeat (2) begin
        step();
        if (mem_start === 1'b1) starts++;
      end
    end
    repeat (4) begin
      step();
      if (mem_start === 1'b1) starts++;
    end
    n_tests++;
    if (starts !== 1 || mem_src !== 2'b11) begin
      n_fail++;
      $display("FAIL ref_inflight: got starts=%0d src=%b, want 1 11", starts, mem_src);
    end
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    for (int g = 0; g < 5; g++) begin
      wait_start(10, seen);
      if (seen) begin
        starts++;
        n_tests++;
        if (mem_src !== 2'b11 || mem_cmd !== 2'b11) begin
          n_fail++;
          $display("FAIL ref_grant_src: got src=%b cmd=%b, want 11 11", mem_src, mem_cmd);
        end
        step();
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
      end
    end
    n_tests++;
    if (starts !== 4 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL ref_saturate: got %0d grants st=%0d, want 4 grants st=0", starts, dbg_state);
    end
  endtask

  task automatic test_timeout();
    bit seen;
    bit early;
    cpu_a = 20'h0F0F0;
    cpu_wr_n = 1'b0;
    wait_start(10, seen);
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL tmo_start: got no MEM_START, want one");
    end
    early = 1'b0;
    for (int i = 0; i < 255; i++) begin
      step();
      if (cpu_wait_n !== 1'b0 || arb_err !== 1'b0 || dbg_state !== 2'd2) early = 1'b1;
    end
    n_tests++;
    if (early) begin
      n_fail++;
      $display("FAIL tmo_hold: got early abort or wait release, want 255 BUSY cycles");
    end
    step();
    n_tests++;
    if (arb_err !== 1'b1 || cpu_wait_n !== 1'b1 || mem_src !== 2'b00 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL tmo_abort: got err=%b wait=%b src=%b st=%0d, want 1 1 00 0",
               arb_err, cpu_wait_n, mem_src, dbg_state);
    end
    cpu_wr_n = 1'b1;
    repeat (5) step();
    n_tests++;
    if (arb_err !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_sticky: got %b, want 1", arb_err);
    end
    // Async reset in the middle of a BUSY video read.
    video_a = 20'h33333;
    video_rd_n = 1'b0;
    wait_start(10, seen);
    video_rd_n = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (arb_err !== 1'b0 || mem_src !== 2'b00 || mem_cmd !== 2'b00 ||
        mem_a !== 20'h0 || dbg_state !== 2'd0 || cpu_wait_n !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got err=%b src=%b cmd=%b a=%0h st=%0d wait=%b, want 0 00 00 0 0 1",
               arb_err, mem_src, mem_cmd, mem_a, dbg_state, cpu_wait_n);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_starve();
    bit seen;
    bit cpu_woke;
    logic [1:0] exp_src;
    apply_reset();
    video_a = 20'h55555;
    video_rd_n = 1'b0;
    cpu_a = 20'h22222;
    cpu_rd_n = 1'b0;
    cpu_woke = 1'b0;
    for (int g = 0; g < 6; g++) begin
      wait_start(12, seen);
      exp_src = 2'b10;
`ifdef CPU_STARVE_GUARD_EN
      if (g == 3) exp_src = 2'b01;
`endif
      n_tests++;
      if (!seen || mem_src !== exp_src) begin
        n_fail++;
        $display("FAIL starve_grant%0d: got seen=%0d src=%b, want 1 %b", g, seen, mem_src, exp_src);
      end
      if (cpu_wait_n !== 1'b0) cpu_woke = 1'b1;
      step();
      mem_done = 1'b1;
      step();
      mem_done = 1'b0;
      if (exp_src == 2'b01) cpu_rd_n = 1'b1;
      else if (cpu_wait_n !== 1'b0) cpu_woke = 1'b1;
    end
`ifndef CPU_STARVE_GUARD_EN
    n_tests++;
    if (cpu_woke) begin
      n_fail++;
      $display("FAIL starve_cpu_wait: got CPU_WAITn=1 at some point, want 0 throughout");
    end
`endif
    video_rd_n = 1'b1;
    cpu_rd_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_priority();
    test_refresh_sat();
    test_timeout();
    test_starve();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
